mdu_seq: RTL and testbench

//  Parametrised RV32M/RV64M multiply-divide unit with a start/done handshake.

---
 rtl/mdu_seq.sv | 164 ++++++++++++++++
 tb/tb_mdu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// RV32M/RV64M multiply-divide unit: single-cycle multiply, radix-2 restoring divide.
// Optional build macro MDU_DIV_BYPASS_EN: divide-by-zero and signed overflow finish in one cycle.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_e;

  state_e            state_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              isRem_q;
  logic              negQ_q;
  logic              negR_q;
  logic              bZero_q;
  logic [XLEN-1:0]   aOrig_q;
  logic [XLEN-1:0]   divisor_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;

  logic              divSigned;
  logic              negA;
  logic              negB;
  logic              bZero;
  logic [XLEN-1:0]   absA;
  logic [XLEN-1:0]   absB;
  logic [2*XLEN-1:0] aExt;
  logic [2*XLEN-1:0] bExt;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mulRes_d;
  logic [XLEN:0]     remShift;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   divRem_d;
  logic [XLEN-1:0]   divQuo_d;
  logic [XLEN-1:0]   quoFinal;
  logic [XLEN-1:0]   remFinal;
  logic [XLEN-1:0]   fixRes_d;

  // Operand conditioning, product slice selection and one restoring step
  always_comb begin
    divSigned = ~funct3_i[0];
    negA      = divSigned & a_i[XLEN-1];
    negB      = divSigned & b_i[XLEN-1];
    absA      = negA ? -a_i : a_i;
    absB      = negB ? -b_i : b_i;
    bZero     = (b_i == '0);

    aExt    = {{XLEN{(funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10) & a_i[XLEN-1]}}, a_i};
    bExt    = {{XLEN{(funct3_i[1:0] == 2'b01) & b_i[XLEN-1]}}, b_i};
    product = aExt * bExt;
    mulRes_d = (funct3_i[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    remShift = {rem_q, quo_q[XLEN-1]};
    trial    = remShift - {1'b0, divisor_q};
    divRem_d = trial[XLEN] ? remShift[XLEN-1:0] : trial[XLEN-1:0];
    divQuo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};

    // Divide by zero must not see the sign fix: quotient all ones, remainder is the raw dividend
    quoFinal = negQ_q ? -quo_q : quo_q;
    remFinal = negR_q ? -rem_q : rem_q;
    if (bZero_q) begin
      quoFinal = '1;
      remFinal = aOrig_q;
    end
    fixRes_d = isRem_q ? remFinal : quoFinal;
  end

`ifdef MDU_DIV_BYPASS_EN
  logic            divOvf;
  logic [XLEN-1:0] specialRes_d;

  always_comb begin
    divOvf       = divSigned & (a_i == MIN_VAL) & (b_i == '1);
    specialRes_d = funct3_i[1] ? (bZero ? a_i : '0) : (bZero ? '1 : MIN_VAL);
  end
`endif

  // Control FSM; result and done are registered here
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
      isRem_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      bZero_q   <= 1'b0;
      aOrig_q   <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (!funct3_i[2]) begin
              result_q <= mulRes_d;
              done_q   <= 1'b1;
            end
`ifdef MDU_DIV_BYPASS_EN
            else if (bZero || divOvf) begin
              result_q <= specialRes_d;
              done_q   <= 1'b1;
            end
`endif
            else begin
              isRem_q   <= funct3_i[1];
              negQ_q    <= negA ^ negB;
              negR_q    <= negA;
              bZero_q   <= bZero;
              aOrig_q   <= a_i;
              divisor_q <= absB;
              quo_q     <= absA;
              rem_q     <= '0;
              cnt_q     <= CNT_INIT;
              state_q   <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= divRem_d;
          quo_q <= divQuo_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fixRes_d;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq at XLEN=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_seq;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   localparam int DIV_LAT = 33;
`ifdef MDU_DIV_BYPASS_EN
   localparam int SPECIAL_LAT = 0;
`else
   localparam int SPECIAL_LAT = 33;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   mdu_seq #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .funct3_i(funct3),
      .a_i     (a),
      .b_i     (b),
      .ready_o (ready),
      .done_o  (done),
      .result_o(result)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Present one request for a single cycle; returns on the falling edge after the accepting edge
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] aVal, input logic [31:0] bVal);
      start  = 1'b1;
      funct3 = f3;
      a      = aVal;
      b      = bVal;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Counts rising edges after the accepting edge until done, bounded
   task automatic waitDone(output int n, output bit sawReady);
      n = 0;
      sawReady = 1'b0;
      while (done !== 1'b1 && n < 100) begin
         if (ready === 1'b1) sawReady = 1'b1;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic runDiv(input string tag, input logic [2:0] f3, input logic [31:0] aVal,
                         input logic [31:0] bVal, input logic [31:0] expRes, input int expLat);
      int  n;
      bit  sawReady;
      applyStimulus(f3, aVal, bVal);
      waitDone(n, sawReady);
      checkOutput({tag, "_latency"}, 64'(n), 64'(expLat));
      checkOutput({tag, "_readyLowBusy"}, 64'(sawReady), 64'd0);
      checkOutput({tag, "_result"}, 64'(result), 64'(expRes));
      checkOutput({tag, "_readyAtDone"}, 64'(ready), 64'd1);
   endtask

   // Directed sequence
   initial begin
      logic [2:0]  mulOps [4];
      logic [31:0] mulExp [4];
      int          n;
      bit          sawReady;
      bit          sawDone;

      mulOps = '{F_MUL, F_MULH, F_MULHU, F_MULHSU};
      mulExp = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

      rst = 1'b1; start = 1'b0; funct3 = 3'b000; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_ready", 64'(ready), 64'd1);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_result", 64'(result), 64'd0);
      @(negedge clk);

      // Back-to-back multiplies with start held high
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         funct3 = mulOps[i];
         @(negedge clk);
         checkOutput($sformatf("mul%0d_done", i), 64'(done), 64'd1);
         checkOutput($sformatf("mul%0d_result", i), 64'(result), 64'(mulExp[i]));
         checkOutput($sformatf("mul%0d_ready", i), 64'(ready), 64'd1);
      end
      start = 1'b0;
      @(negedge clk);
      checkOutput("mul_donePulse", 64'(done), 64'd0);
      checkOutput("mul_resultHold", 64'(result), 64'hFFFF_FFFF);

      runDiv("div_m7_2",  F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
      runDiv("rem_m7_2",  F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
      runDiv("divu_m7_2", F_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DIV_LAT);
      runDiv("remu_m7_2", F_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, DIV_LAT);
      runDiv("div_100_7", F_DIV,  32'd100,       32'd7, 32'd14,        DIV_LAT);

      runDiv("div_m5_0",  F_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
      runDiv("divu_m5_0", F_DIVU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
      runDiv("rem_m5_0",  F_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT);
      runDiv("remu_m5_0", F_REMU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT);

      runDiv("div_ovf",  F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
      runDiv("rem_ovf",  F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPECIAL_LAT);
      runDiv("divu_min", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);

      // Reset ten cycles into a divide aborts it silently
      applyStimulus(F_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_result", 64'(result), 64'd0);
      checkOutput("abort_ready", 64'(ready), 64'd1);
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      checkOutput("abort_noDone", 64'(sawDone), 64'd0);
      applyStimulus(F_MUL, 32'd3, 32'd4);
      checkOutput("abort_mulDone", 64'(done), 64'd1);
      checkOutput("abort_mulResult", 64'(result), 64'd12);
      @(negedge clk);

      // Starts while busy are ignored; a start in the done cycle is accepted
      applyStimulus(F_DIV, 32'd100, 32'd7);
      n = 0;
      sawDone = 1'b0;
      start = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         funct3 = (n % 2 == 0) ? F_DIV : F_MUL;
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         n++;
      end
      checkOutput("busyStart_latency", 64'(n), 64'(DIV_LAT));
      checkOutput("busyStart_result", 64'(result), 64'd14);
      funct3 = F_MUL; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      checkOutput("doneCycleStart_done", 64'(done), 64'd1);
      checkOutput("doneCycleStart_result", 64'(result), 64'd42);
      waitDone(n, sawReady);
      @(negedge clk);
      checkOutput("final_doneLow", 64'(done), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
